// File: rtl/bs_writer_pkg.sv
// Shared types and helpers for the bitstream memory writer.
package bs_writer_pkg;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] val;
    logic [2:0]  size;
  } patch_t;

  typedef enum logic [1:0] {IDLE, DATA, PATCH0, PATCH1} issue_state_t;

  // Byte enables for a partial flush word holding n leading bytes.
  function automatic logic [3:0] be_leading(input logic [1:0] n);
    case (n)
      2'd1:    return 4'b1000;
      2'd2:    return 4'b1100;
      2'd3:    return 4'b1110;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO accepting up to three writes per cycle and one read.
// The writer must check o_free_count before pushing; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [1:0]                 i_wr_cnt,
  input  logic [3*WIDTH-1:0]         i_wr_data,
  input  logic                       i_rd_en,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_free_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_rd;

  assign o_empty      = (r_count == '0);
  assign o_free_count = CNT_W'(DEPTH) - r_count;
  assign o_rd_data    = r_mem[r_rdPtr];
  assign w_rd         = i_rd_en && !o_empty;

  // Lane 0 lands at the write pointer, later lanes follow in order.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < i_wr_cnt) r_mem[r_wrPtr + PTR_W'(i)] <= i_wr_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      r_wrPtr <= r_wrPtr + PTR_W'(i_wr_cnt);
      if (w_rd) r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count + CNT_W'(i_wr_cnt) - CNT_W'(w_rd);
    end
  end

endmodule

// File: rtl/bitstream_mem_writer.sv
// Packs the encoder byte stream into big-endian words, queues them, and writes them to
// frame memory, interleaving size-field back-patches once their bytes are in memory.
module bitstream_mem_writer
  import bs_writer_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                FIFO_DEPTH  = 16,
  parameter int                PATCH_DEPTH = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [3:0]        in_byte_num,
  input  logic [63:0]       in_val,
  input  logic [31:0]       patch_addr,
  input  logic [31:0]       patch_val,
  input  logic [31:0]       patch_byte_size,
  input  logic              frame_end,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  output logic [31:0]       total_bytes,
  output logic              overflow,
  output logic              busy
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PCNT_W = $clog2(PATCH_DEPTH) + 1;
  localparam int DW     = 36;
  localparam int PW     = $bits(patch_t);

  issue_state_t      r_state, w_next;
  logic [23:0]       r_res;
  logic [1:0]        r_resCnt;
  logic [31:0]       r_totalBytes, r_memBytes;
  logic              r_overflow;
  logic [ADDR_W-1:0] r_dataAddr;

  logic [3:0]        w_n, w_total;
  logic [1:0]        w_full, w_rem, w_pushCnt, w_dataPush;
  logic              w_flush, w_patchReq, w_dataDrop, w_patchDrop, w_drop, w_patchPush;
  logic [87:0]       w_cat, w_mask, w_catM;
  logic [2:0][31:0]  w_word;
  logic [23:0]       w_resNext;
  logic [3*DW-1:0]   w_dataLanes;
  logic [3*PW-1:0]   w_patchLanes;
  logic [DW-1:0]     w_dh;
  logic              w_dataEmpty, w_patchEmpty;
  logic [FCNT_W-1:0] w_dataFree;
  logic [PCNT_W-1:0] w_patchFree;
  patch_t            w_ph;
  logic [1:0]        w_off;
  logic [7:0]        w_beSpan;
  logic [63:0]       w_valSpan;
  logic              w_split, w_elig, w_accept, w_popData, w_popPatch;
  logic              w_selData, w_selP0, w_selP1;
  logic [31:0]       w_patchEnd;
  logic [ADDR_W-1:0] w_patchWordAddr;

  // Residual bytes sit MSB-first on top; new bytes follow directly behind them.
  assign w_n     = (in_byte_num > 4'd8) ? 4'd0 : in_byte_num;
  assign w_total = {2'b00, r_resCnt} + w_n;
  assign w_cat   = {r_res, 64'h0} | ({in_val, 24'h0} >> (8 * r_resCnt));
  assign w_mask  = ~({88{1'b1}} >> (8 * w_total));
  assign w_catM  = w_cat & w_mask;
  assign w_full  = w_total[3:2];
  assign w_rem   = w_total[1:0];
  assign w_flush = frame_end && (w_rem != 2'd0);
  assign w_pushCnt = w_full + 2'(w_flush);

  assign w_word[0] = w_catM[87:56];
  assign w_word[1] = w_catM[55:24];
  assign w_word[2] = {w_catM[23:0], 8'h00};

  always_comb begin
    w_dataLanes = '0;
    for (int i = 0; i < 3; i++) begin
      w_dataLanes[i*DW +: DW] = {w_word[i], (i < int'(w_full)) ? 4'hF : be_leading(w_rem)};
    end
    case (w_full)
      2'd0:    w_resNext = w_catM[87:64];
      2'd1:    w_resNext = w_catM[55:32];
      default: w_resNext = w_catM[23:0];
    endcase
  end

  // A cycle that cannot be fully queued is dropped as a whole, patch included.
  assign w_patchReq   = (patch_byte_size != 32'd0) && (patch_byte_size <= 32'd4);
  assign w_dataDrop   = FCNT_W'(w_pushCnt) > w_dataFree;
  assign w_patchDrop  = w_patchReq && (w_patchFree == '0);
  assign w_drop       = w_dataDrop || w_patchDrop;
  assign w_dataPush   = w_drop ? 2'd0 : w_pushCnt;
  assign w_patchPush  = w_patchReq && !w_drop;
  assign w_patchLanes = {{(2*PW){1'b0}}, patch_addr, patch_val, patch_byte_size[2:0]};

  sync_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_dataFifo (
    .clock(clock), .reset_n(reset_n),
    .i_wr_cnt(w_dataPush), .i_wr_data(w_dataLanes), .i_rd_en(w_popData),
    .o_rd_data(w_dh), .o_empty(w_dataEmpty), .o_free_count(w_dataFree)
  );

  sync_fifo #(.WIDTH(PW), .DEPTH(PATCH_DEPTH)) u_patchFifo (
    .clock(clock), .reset_n(reset_n),
    .i_wr_cnt({1'b0, w_patchPush}), .i_wr_data(w_patchLanes), .i_rd_en(w_popPatch),
    .o_rd_data(w_ph), .o_empty(w_patchEmpty), .o_free_count(w_patchFree)
  );

  // Patch value laid out across an 8-byte window starting at its word; second half is beat 1.
  assign w_off           = w_ph.addr[1:0];
  assign w_beSpan        = 8'(8'hFF << (4'd8 - {1'b0, w_ph.size})) >> w_off;
  assign w_valSpan       = ({w_ph.val, 32'h0} << (6'd32 - {w_ph.size, 3'b000})) >> {w_off, 3'b000};
  assign w_split         = |w_beSpan[3:0];
  assign w_patchEnd      = w_ph.addr + {29'h0, w_ph.size};
  assign w_elig          = !w_patchEmpty && (w_patchEnd <= r_memBytes);
  assign w_patchWordAddr = BASE_ADDR + ADDR_W'({w_ph.addr[31:2], 2'b00});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // IDLE presents a fresh choice at once; an unaccepted beat locks into its state to stay stable.
  always_comb begin
    w_next     = r_state;
    w_selData  = 1'b0;
    w_selP0    = 1'b0;
    w_selP1    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    case (r_state)
      IDLE: begin
        if (w_elig)            w_selP0   = 1'b1;
        else if (!w_dataEmpty) w_selData = 1'b1;
      end
      DATA:    w_selData = 1'b1;
      PATCH0:  w_selP0   = 1'b1;
      PATCH1:  w_selP1   = 1'b1;
      default: ;
    endcase
    mem_wr_en  = w_selData || w_selP0 || w_selP1;
    w_accept   = mem_wr_en && mem_ready;
    w_popData  = w_selData && w_accept;
    w_popPatch = w_accept && (w_selP1 || (w_selP0 && !w_split));
    if (w_selData) begin
      mem_addr  = r_dataAddr;
      mem_wdata = w_dh[35:4];
      mem_be    = w_dh[3:0];
      w_next    = w_accept ? IDLE : DATA;
    end else if (w_selP0) begin
      mem_addr  = w_patchWordAddr;
      mem_wdata = w_valSpan[63:32];
      mem_be    = w_beSpan[7:4];
      w_next    = w_accept ? (w_split ? PATCH1 : IDLE) : PATCH0;
    end else if (w_selP1) begin
      mem_addr  = w_patchWordAddr + ADDR_W'(WORD_BYTES);
      mem_wdata = w_valSpan[31:0];
      mem_be    = w_beSpan[3:0];
      w_next    = w_accept ? IDLE : PATCH1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_res        <= '0;
      r_resCnt     <= '0;
      r_totalBytes <= '0;
      r_overflow   <= 1'b0;
      r_dataAddr   <= BASE_ADDR;
      r_memBytes   <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else begin
        r_totalBytes <= r_totalBytes + 32'(w_n);
        r_res        <= frame_end ? 24'h0 : w_resNext;
        r_resCnt     <= frame_end ? 2'd0 : w_rem;
      end
      if (w_popData) begin
        r_dataAddr <= r_dataAddr + ADDR_W'(WORD_BYTES);
        r_memBytes <= r_memBytes + 32'($countones(w_dh[3:0]));
      end
    end
  end

  assign total_bytes = r_totalBytes;
  assign overflow    = r_overflow;
  assign busy        = (r_resCnt != 2'd0) || !w_dataEmpty || !w_patchEmpty || mem_wr_en;

endmodule
